dense2_argmax: RTL and testbench

//   Final classification stage; sits directly downstream of the second dense layer.

---
 rtl/dense2_argmax.sv | 126 ++++++++++++
 tb/tb_dense2_argmax.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dense2_argmax.sv
// Argmax over the ten signed sums of the second dense layer.
// Captures a frame, scans it one element per enabled cycle and strobes the winning class.
module dense2_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic                              valid_in,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] dense_sum_in,
  output logic                              busy,
  output logic                              class_valid,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             class_max,
  output logic                              drop_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);

  state_t                            state_r;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] cap_r;
  logic [IDX_WIDTH-1:0]              cnt_r;
  logic [IDX_WIDTH-1:0]              best_idx_r;
  logic [DATA_WIDTH-1:0]             best_val_r;
  logic [DATA_WIDTH-1:0]             elem_s;
  logic                              greater_s;

  // Strict signed greater-than: ties leave the earlier (lower) index in place.
  function automatic logic gt_signed(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

  // Select the captured element addressed by the scan counter.
  always_comb begin
    elem_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt_r == IDX_WIDTH'(i)) begin
        elem_s = cap_r[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        elem_s = elem_s;
      end
    end
  end

  // Compare the current element against the running best.
  always_comb begin
    greater_s = gt_signed(elem_s, best_val_r);
  end

  // Control FSM, scan datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cap_r       <= {(NUM_CLASSES*DATA_WIDTH){1'b0}};
      cnt_r       <= {IDX_WIDTH{1'b0}};
      best_idx_r  <= {IDX_WIDTH{1'b0}};
      best_val_r  <= {DATA_WIDTH{1'b0}};
      busy        <= 1'b0;
      class_valid <= 1'b0;
      class_idx   <= {IDX_WIDTH{1'b0}};
      class_max   <= {DATA_WIDTH{1'b0}};
      drop_err    <= 1'b0;
    end else if (!ena) begin
      class_valid <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_in) begin
            cap_r      <= dense_sum_in;
            best_val_r <= dense_sum_in[DATA_WIDTH-1:0];
            best_idx_r <= {IDX_WIDTH{1'b0}};
            cnt_r      <= ONE_IDX;
            state_r    <= SCAN;
            busy       <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        SCAN: begin
          // A frame offered while busy is lost; remember that it happened.
          if (valid_in) begin
            drop_err <= 1'b1;
          end
          if (greater_s) begin
            best_val_r <= elem_s;
            best_idx_r <= cnt_r;
          end
          cnt_r <= cnt_r + ONE_IDX;
          if (cnt_r == LAST_IDX) begin
            state_r <= DONE;
          end else begin
            state_r <= SCAN;
          end
          busy <= 1'b1;
        end
        DONE: begin
          if (valid_in) begin
            drop_err <= 1'b1;
          end
          class_idx   <= best_idx_r;
          class_max   <= best_val_r;
          class_valid <= 1'b1;
          state_r     <= IDLE;
          busy        <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense2_argmax.sv
// Directed bench for dense2_argmax with a queue-based scoreboard and strobe monitor.
module tb_dense2_argmax;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         valid_in;
  logic [159:0] dense_sum_in;
  logic         busy;
  logic         class_valid;
  logic [3:0]   class_idx;
  logic [15:0]  class_max;
  logic         drop_err;

  dense2_argmax dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .valid_in     (valid_in),
    .dense_sum_in (dense_sum_in),
    .busy         (busy),
    .class_valid  (class_valid),
    .class_idx    (class_idx),
    .class_max    (class_max),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [15:0] mx;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (class_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got idx=%0d max=0x%h at cyc=%0d, expected none",
                 class_idx, class_max, cyc);
      end else begin
        e = sbq.pop_front();
        chk("class_idx", 32'(class_idx), 32'(e.idx));
        chk("class_max", 32'(class_max), 32'(e.mx));
        chk("strobe_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  function automatic logic [159:0] fill(input logic [15:0] v);
    logic [159:0] d;
    for (int i = 0; i < 10; i++) d[i*16 +: 16] = v;
    return d;
  endfunction

  // Called just after a negedge; returns one cycle later, right after the capture edge.
  task automatic issue(input logic [159:0] d, input int eidx, input logic [15:0] emax,
                       input int stall, input bit push);
    exp_t e;
    valid_in     = 1'b1;
    dense_sum_in = d;
    if (push) begin
      e.idx = eidx;
      e.mx  = emax;
      e.at  = cyc + 11 + stall;
      sbq.push_back(e);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    @(negedge clk);
  endtask

  logic [159:0] d1, d;

  initial begin
    rst = 1'b1; ena = 1'b1; valid_in = 1'b0; dense_sum_in = 160'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_class_valid", 32'(class_valid), 32'd0);
    chk("rst_class_idx", 32'(class_idx), 32'd0);
    chk("rst_class_max", 32'(class_max), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single winner, busy window
    d1 = fill(16'hFFFB);
    d1[7*16 +: 16] = 16'h0123;
    issue(d1, 7, 16'h0123, 0, 1'b1);
    chk("t1_busy_start", 32'(busy), 32'd1);
    repeat (9) @(negedge clk);
    chk("t1_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_end", 32'(busy), 32'd0);
    drain();

    // 2: all equal, lowest index wins
    issue(fill(16'h0100), 0, 16'h0100, 0, 1'b1);
    drain();

    // 3: signed compare extremes
    d = fill(16'h8000);
    d[9*16 +: 16] = 16'hFFFF;
    issue(d, 9, 16'hFFFF, 0, 1'b1);
    drain();
    d = fill(16'h8000);
    d[3*16 +: 16] = 16'h7FFF;
    issue(d, 3, 16'h7FFF, 0, 1'b1);
    drain();

    // 4: three frozen cycles mid-scan
    issue(d1, 7, 16'h0123, 3, 1'b1);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    drain();

    // 5: dropped frame while busy, then back-to-back acceptance
    d = fill(16'h0010);
    d[5*16 +: 16] = 16'h0050;
    issue(d, 5, 16'h0050, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_drop_before", 32'(drop_err), 32'd0);
    valid_in = 1'b1;
    dense_sum_in = fill(16'h0000);
    dense_sum_in[1*16 +: 16] = 16'h7FFF;
    @(negedge clk);
    valid_in = 1'b0;
    chk("t5_drop_after", 32'(drop_err), 32'd1);
    repeat (6) @(negedge clk);
    d = fill(16'h0001);
    d[8*16 +: 16] = 16'h7000;
    issue(d, 8, 16'h7000, 0, 1'b1);
    drain();
    chk("t5_drop_sticky", 32'(drop_err), 32'd1);

    // 6: reset in the middle of a scan aborts the frame
    issue(fill(16'h0200), 0, 16'h0200, 0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_class_valid", 32'(class_valid), 32'd0);
    chk("t6_class_idx", 32'(class_idx), 32'd0);
    chk("t6_class_max", 32'(class_max), 32'd0);
    chk("t6_drop_err", 32'(drop_err), 32'd0);
    repeat (14) @(negedge clk);
    issue(d1, 7, 16'h0123, 0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
